rf_op_sequencer: RTL

Command-driven controller that sequences the 8-register file (T1-T4, R1-R4) through multi-cycle micro-operations: clear, load, move, increment, decrement and swap. It accepts one command per valid/ready handshake and drives the file's O1Sel/O2Sel/FunSel/RSel/TSel controls. It also supplies the file's write-data input, either from an external immediate or fed back from O1. It sits between the instruction-decode logic and the register file, and is the only writer of the file.

---
 rtl/rf_seq_pkg.sv | 29 ++
 rtl/rf_op_sequencer_idx_decode.sv | 18 +
 rtl/rf_op_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rf_seq_pkg.sv
// Shared constants and state type for the register-file op sequencer.
package rf_seq_pkg;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_CLR = 3'b001;
   localparam logic [2:0] OP_LD  = 3'b010;
   localparam logic [2:0] OP_MOV = 3'b011;
   localparam logic [2:0] OP_INC = 3'b100;
   localparam logic [2:0] OP_DEC = 3'b101;
   localparam logic [2:0] OP_SWP = 3'b110;
   localparam logic [2:0] OP_ILL = 3'b111;

   localparam logic [1:0] FS_CLR = 2'b00;
   localparam logic [1:0] FS_LD  = 2'b01;
   localparam logic [1:0] FS_DEC = 2'b10;
   localparam logic [1:0] FS_INC = 2'b11;

   localparam logic [2:0] SCRATCH_DEFAULT = 3'b011;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_SWP1,
      S_SWP2,
      S_SWP3,
      S_FAULT
   } state_t;

endpackage

// File: rtl/rf_op_sequencer_idx_decode.sv
// Maps a 3-bit register index onto the file's one-hot RSel/TSel pair (MSB = R1/T1).
module rf_idx_decode (
   input  logic       en,
   input  logic [2:0] idx,
   output logic [3:0] rsel,
   output logic [3:0] tsel
);

   always_comb begin
      rsel = '0;
      tsel = '0;
      if (en) begin
         if (idx[2]) rsel = 4'b1000 >> idx[1:0];
         else        tsel = 4'b1000 >> idx[1:0];
      end
   end

endmodule

// File: rtl/rf_op_sequencer.sv
// Command-driven sequencer: turns clear/load/move/inc/dec/swap commands into
// register-file control steps; the only writer of the file.
module rf_op_sequencer
   import rf_seq_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter logic [2:0]  SCRATCH = SCRATCH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [2:0]       cmd_dst,
   input  logic [2:0]       cmd_src,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             done,
   output logic             err,
   output logic             busy,
   input  logic [2:0]       rd_sel,
   input  logic [WIDTH-1:0] rf_o1,
   output logic [WIDTH-1:0] rf_i,
   output logic [2:0]       rf_o1sel,
   output logic [2:0]       rf_o2sel,
   output logic [1:0]       rf_funsel,
   output logic [3:0]       rf_rsel,
   output logic [3:0]       rf_tsel
);

   state_t           state, state_nx;
   logic [2:0]       op_q, dst_q, src_q;
   logic [WIDTH-1:0] data_q;
   logic             wr_en, use_o1, use_data;
   logic [2:0]       wr_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         op_q   <= '0;
         dst_q  <= '0;
         src_q  <= '0;
         data_q <= '0;
      end else begin
         state <= state_nx;
         if (cmd_valid && cmd_ready) begin
            op_q   <= cmd_op;
            dst_q  <= cmd_dst;
            src_q  <= cmd_src;
            data_q <= cmd_data;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      err       = 1'b0;
      wr_en     = 1'b0;
      wr_idx    = dst_q;
      rf_funsel = FS_CLR;
      rf_o1sel  = '0;
      use_o1    = 1'b0;
      use_data  = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               // Swaps touching the scratch register would corrupt an operand.
               if (cmd_op == OP_ILL ||
                   (cmd_op == OP_SWP && (cmd_dst == SCRATCH || cmd_src == SCRATCH)))
                  state_nx = S_FAULT;
               else if (cmd_op == OP_SWP)
                  state_nx = S_SWP1;
               else
                  state_nx = S_EXEC;
            end
         end
         S_EXEC: begin
            done     = 1'b1;
            state_nx = S_IDLE;
            case (op_q)
               OP_CLR: begin wr_en = 1'b1; rf_funsel = FS_CLR; end
               OP_LD:  begin wr_en = 1'b1; rf_funsel = FS_LD; use_data = 1'b1; end
               OP_MOV: begin
                  wr_en     = 1'b1;
                  rf_funsel = FS_LD;
                  rf_o1sel  = src_q;
                  use_o1    = 1'b1;
               end
               OP_INC: begin wr_en = 1'b1; rf_funsel = FS_INC; end
               OP_DEC: begin wr_en = 1'b1; rf_funsel = FS_DEC; end
               default: ;
            endcase
         end
         S_SWP1: begin
            wr_en = 1'b1; wr_idx = SCRATCH; rf_funsel = FS_LD;
            rf_o1sel = dst_q; use_o1 = 1'b1; state_nx = S_SWP2;
         end
         S_SWP2: begin
            wr_en = 1'b1; wr_idx = dst_q; rf_funsel = FS_LD;
            rf_o1sel = src_q; use_o1 = 1'b1; state_nx = S_SWP3;
         end
         S_SWP3: begin
            wr_en = 1'b1; wr_idx = src_q; rf_funsel = FS_LD;
            rf_o1sel = SCRATCH; use_o1 = 1'b1; done = 1'b1; state_nx = S_IDLE;
         end
         S_FAULT: begin
            err      = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign rf_i     = use_o1 ? rf_o1 : (use_data ? data_q : '0);
   assign rf_o2sel = rd_sel;

   rf_idx_decode u_idx_decode (
      .en   (wr_en),
      .idx  (wr_idx),
      .rsel (rf_rsel),
      .tsel (rf_tsel)
   );

endmodule
